// File: rtl/brnch_pred_pkg.sv
// Shared widths and types for the branch target buffer / branch resolution slice.
package brnch_pred_pkg;

    localparam int PC_W        = 32;
    localparam int BTB_ENTRIES = 16;
    localparam int IDX_W       = $clog2(BTB_ENTRIES);
    localparam int TAG_W       = PC_W - IDX_W - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
    } btb_entry_t;

    typedef struct packed {
        logic            vld;
        logic [PC_W-1:0] pc;
        logic            pred_taken;
        logic [PC_W-1:0] pred_tgt;
    } ifid_brch_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } res_state_e;

endpackage

// File: rtl/btb_regs.sv
// BTB entry storage: asynchronous read port and one synchronous write port.
// Only the valid bits are reset; tag/target payloads are masked by valid.
module btb_regs #(
    parameter  int BTB_ENTRIES = brnch_pred_pkg::BTB_ENTRIES,
    localparam int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IDX_W-1:0]           rd_idx_i,
    output brnch_pred_pkg::btb_entry_t rd_entry_o,
    input  logic                       wr_en_i,
    input  logic [IDX_W-1:0]           wr_idx_i,
    input  brnch_pred_pkg::btb_entry_t wr_entry_i
);
    import brnch_pred_pkg::*;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [PC_W-1:0]        tgt_q [BTB_ENTRIES];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= wr_entry_i.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i] <= wr_entry_i.tag;
            tgt_q[wr_idx_i] <= wr_entry_i.target;
        end
    end

    // Read sees pre-write contents when the same index is written this cycle.
    assign rd_entry_o = '{valid:  valid_q[rd_idx_i],
                          tag:    tag_q[rd_idx_i],
                          target: tgt_q[rd_idx_i]};

endmodule

// File: rtl/brnch_tgt_buf_resolve.sv
// BTB lookup/redirect in IF plus branch resolution and one-cycle flush in ID.
// Define BTB_STATS_EN to add saturating resolution/mispredict counters.
module brnch_tgt_buf_resolve #(
    parameter  int PC_W        = brnch_pred_pkg::PC_W,
    parameter  int BTB_ENTRIES = brnch_pred_pkg::BTB_ENTRIES,
    localparam int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [PC_W-1:0] if_pc,
    input  logic            predict_br_taken,
    input  logic            id_stall,
    input  logic            id_brch_valid,
    input  logic            id_actual_taken,
    input  logic [PC_W-1:0] id_actual_target,
    output logic            pred_redirect,
    output logic [PC_W-1:0] pred_target,
    output logic [4:0]      brch_addr_lw_5b,
    output logic            mispredict_flush,
    output logic [PC_W-1:0] correct_pc,
    output logic [31:0]     stat_brch_cnt,
    output logic [31:0]     stat_misp_cnt
);
    import brnch_pred_pkg::*;

    res_state_e               state_q, state_d;
    ifid_brch_t               ifid_q, ifid_d;
    logic [PC_W-1:0]          correct_pc_q, correct_pc_d;
    btb_entry_t               rd_entry, wr_entry;
    logic [IDX_W-1:0]         if_idx;
    logic [PC_W-IDX_W-3:0]    if_tag;
    logic                     hit, res_fire, mispredict, btb_we;

    assign if_idx          = if_pc[IDX_W+1:2];
    assign if_tag          = if_pc[PC_W-1:IDX_W+2];
    assign brch_addr_lw_5b = if_pc[6:2];

    btb_regs #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (if_idx),
        .rd_entry_o (rd_entry),
        .wr_en_i    (btb_we),
        .wr_idx_i   (ifid_q.pc[IDX_W+1:2]),
        .wr_entry_i (wr_entry)
    );

    assign hit           = rd_entry.valid && (rd_entry.tag == if_tag);
    assign pred_redirect = if_valid && predict_br_taken && hit && (state_q == RUN);
    assign pred_target   = hit ? rd_entry.target : '0;

    // A taken branch with a correct direction but stale target still mispredicts.
    assign res_fire   = id_brch_valid && ifid_q.vld && !id_stall && (state_q == RUN);
    assign mispredict = res_fire &&
                        ((id_actual_taken != ifid_q.pred_taken) ||
                         (id_actual_taken && ifid_q.pred_taken &&
                          (id_actual_target != ifid_q.pred_tgt)));
    assign btb_we     = res_fire && id_actual_taken;
    assign wr_entry   = '{valid:  1'b1,
                          tag:    ifid_q.pc[PC_W-1:IDX_W+2],
                          target: id_actual_target};

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= RUN;
            ifid_q       <= '0;
            correct_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            ifid_q       <= ifid_d;
            correct_pc_q <= correct_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        correct_pc_d = correct_pc_q;
        case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d      = FLUSH;
                    correct_pc_d = id_actual_taken ? id_actual_target
                                                   : ifid_q.pc + PC_W'(4);
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Wrong-path instructions are squashed both at the mispredict edge and during the flush.
    always_comb begin
        ifid_d = ifid_q;
        if (mispredict || (state_q == FLUSH)) begin
            ifid_d.vld = 1'b0;
        end else if (!id_stall) begin
            ifid_d = '{vld:        if_valid,
                       pc:         if_pc,
                       pred_taken: pred_redirect,
                       pred_tgt:   pred_target};
        end
    end

    assign mispredict_flush = (state_q == FLUSH);
    assign correct_pc       = correct_pc_q;

`ifdef BTB_STATS_EN
    logic [31:0] brch_cnt_q, misp_cnt_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            brch_cnt_q <= '0;
            misp_cnt_q <= '0;
        end else begin
            if (res_fire && (brch_cnt_q != '1)) brch_cnt_q <= brch_cnt_q + 32'd1;
            if (mispredict && (misp_cnt_q != '1)) misp_cnt_q <= misp_cnt_q + 32'd1;
        end
    end

    assign stat_brch_cnt = brch_cnt_q;
    assign stat_misp_cnt = misp_cnt_q;
`else
    assign stat_brch_cnt = '0;
    assign stat_misp_cnt = '0;
`endif

endmodule
